// File: rtl/harvard_mem_checker.sv
// harvard_mem_checker: watches a MIPS CPU's active flag, waits for halt (with a
// watchdog), then sweeps a block of data-RAM words and compares each against an
// arithmetic progression, reporting pass/fail, mismatch count and first failure.
module harvard_mem_checker #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_active,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       exp_base,
    input  logic [31:0]       exp_stride,
    input  logic [CNT_W-1:0]  word_count,
    output logic [31:0]       mem_address,
    output logic              mem_read,
    input  logic [31:0]       mem_readdata,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [31:0]       first_fail_addr,
    output logic [31:0]       first_fail_data
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_SWEEP   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [WD_W-1:0]  wd_q,     wd_d;
    logic [31:0]      addr_q,   addr_d;
    logic [31:0]      exp_q,    exp_d;
    logic [31:0]      stride_q, stride_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] idx_q,    idx_d;
    logic             rd_q,     rd_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;
    logic             tmo_q,    tmo_d;
    logic [CNT_W-1:0] mcnt_q,   mcnt_d;
    logic [31:0]      ffa_q,    ffa_d;
    logic [31:0]      ffd_q,    ffd_d;
    logic             miss;

    // Next-state logic: watchdog, halt detection, config latch and word compare
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        addr_d   = addr_q;
        exp_d    = exp_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rd_d     = rd_q;
        done_d   = done_q;
        pass_d   = pass_q;
        tmo_d    = tmo_q;
        mcnt_d   = mcnt_q;
        ffa_d    = ffa_q;
        ffd_d    = ffd_q;
        miss     = 1'b0;

        case (state_q)
            S_IDLE, S_RUNNING: begin
                if ((state_q == S_RUNNING) && !cpu_active) begin
                    // Halt wins over the watchdog on the same edge
                    if (word_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d  = S_SWEEP;
                        rd_d     = 1'b1;
                        addr_d   = base_addr & ~32'd3;
                        exp_d    = exp_base;
                        stride_d = exp_stride;
                        cnt_d    = word_count;
                        idx_d    = '0;
                    end
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                    pass_d  = 1'b0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if ((state_q == S_IDLE) && cpu_active) begin
                        state_d = S_RUNNING;
                    end
                end
            end

            S_SWEEP: begin
                miss = (mem_readdata != exp_q);
                if (miss) begin
                    if (mcnt_q != '1) begin
                        mcnt_d = mcnt_q + CNT_W'(1);
                    end
                    if (mcnt_q == '0) begin
                        ffa_d = addr_q;
                        ffd_d = mem_readdata;
                    end
                end
                exp_d  = exp_q + stride_q;
                addr_d = addr_q + 32'd4;
                idx_d  = idx_q + CNT_W'(1);
                if (idx_q == cnt_q - CNT_W'(1)) begin
                    state_d = S_DONE;
                    rd_d    = 1'b0;
                    addr_d  = '0;
                    done_d  = 1'b1;
                    pass_d  = (mcnt_q == '0) && !miss;
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wd_q     <= '0;
            addr_q   <= '0;
            exp_q    <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            rd_q     <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            tmo_q    <= 1'b0;
            mcnt_q   <= '0;
            ffa_q    <= '0;
            ffd_q    <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            addr_q   <= addr_d;
            exp_q    <= exp_d;
            stride_q <= stride_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rd_q     <= rd_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            tmo_q    <= tmo_d;
            mcnt_q   <= mcnt_d;
            ffa_q    <= ffa_d;
            ffd_q    <= ffd_d;
        end
    end

    assign mem_address     = addr_q;
    assign mem_read        = rd_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = tmo_q;
    assign mismatch_count  = mcnt_q;
    assign first_fail_addr = ffa_q;
    assign first_fail_data = ffd_q;

endmodule

// File: doc/harvard_mem_checker.md
Name: harvard_mem_checker

Overview:
Self-checking result stage downstream of mips_cpu_harvard and its data RAM in the harvard testbenches. It watches the CPU's active output. Once the program halts, it takes over the data-RAM read port and sweeps a block of words. Each word is compared against an arithmetic progression, and the block reports pass/fail, the mismatch count and the first failing location. This replaces hand-written post-run check loops, and a watchdog flags programs that never halt.

Parameters:
CNT_W, 16, width of word_count, the sweep index and mismatch_count
TIMEOUT_CYCLES, 2000, cycles allowed from arming to the CPU halting before a timeout is declared (must be >=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; returns the FSM to IDLE
cpu_active  input  1  active output of mips_cpu_harvard
base_addr  input  32  byte address of the first checked word; bits [1:0] ignored and treated as 00
exp_base  input  32  expected value of word 0
exp_stride  input  32  increment between consecutive expected words
word_count  input  CNT_W  number of words to check
mem_address  output  32  data-RAM address, muxed onto the RAM by the bench whenever mem_read=1
mem_read  output  1  read strobe to the data RAM
mem_readdata  input  32  combinational read data from the data RAM
done  output  1  check finished (sticky until reset)
pass  output  1  valid only when done=1; 1 means no mismatch and no timeout
timeout  output  1  CPU did not halt within TIMEOUT_CYCLES
mismatch_count  output  CNT_W  number of mismatching words, saturating at all-ones
first_fail_addr  output  32  address of the first mismatching word
first_fail_data  output  32  data read at first_fail_addr

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; internal counters 0.
- FSM states: IDLE, RUNNING, SWEEP, DONE.
- IDLE: waits for cpu_active=1, then moves to RUNNING. The watchdog counts every cycle in IDLE and RUNNING.
- RUNNING: when cpu_active=0 is sampled on a clock edge, the FSM moves to SWEEP.
  - On that same edge, base_addr (low 2 bits cleared), exp_base, exp_stride and word_count are latched.
  - Sweep index k and the running expected value are cleared to 0 and exp_base respectively.
  - Later changes to the config inputs have no effect on the sweep in progress.
- Watchdog: when the counter reaches TIMEOUT_CYCLES in IDLE or RUNNING, the FSM moves to DONE with timeout=1 and pass=0. The halt check has priority over the watchdog on the same edge.
- SWEEP: one word per cycle.
  - mem_read=1.
  - mem_address = base + 4*k, modulo 2^32, so the address wraps past 0xFFFFFFFC to 0x00000000.
  - mem_readdata is sampled on the clock edge that ends each cycle.
  - expected(k) = exp_base + k*exp_stride, modulo 2^32, held in an accumulator that adds exp_stride each cycle.
  - On a mismatch, mismatch_count increments (saturating at all-ones). On the first mismatch only, first_fail_addr and first_fail_data are captured.
  - After word k = word_count-1 is compared, the FSM moves to DONE. A sweep of N words therefore spends N cycles in SWEEP.
- word_count=0: SWEEP lasts 0 cycles. The FSM goes from RUNNING straight to DONE with pass=1 and mem_read never asserted.
- Outside SWEEP: mem_read=0 and mem_address=0.
- DONE: done=1, and pass = (mismatch_count==0) & ~timeout. All outputs hold until reset, and cpu_active is ignored.
- Reset at any point, including mid-SWEEP, takes effect immediately (asynchronous): mem_read drops, outputs clear, FSM=IDLE.
- cpu_active pulses while in IDLE: a 1 followed by a 0 is treated as a full run followed by a halt.

Test Plan:
- Matching sweep: exp_base=0x12345678, exp_stride=0xDCBB2345, base_addr=0x480, word_count=30, RAM preloaded with matching values. CPU active for 10 cycles, then halts -> 30 cycles with mem_read=1, addresses 0x480..0x4F4, then done=1, pass=1, mismatch_count=0.
- Same setup with word 5 (address 0x494) corrupted to 0xDEADBEEF -> done=1, pass=0, mismatch_count=1, first_fail_addr=0x494, first_fail_data=0xDEADBEEF.
- word_count=0 with the CPU halting -> done=1 and pass=1 on the edge the halt is sampled; mem_read never goes high.
- cpu_active held at 1 with TIMEOUT_CYCLES=50 -> done=1, timeout=1, pass=0 after 50 cycles; mem_read never goes high.
- Wrap-around: base_addr=0xFFFFFFF8 (low bits set to 0xFFFFFFFB to check they are ignored), word_count=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset asserted on the 3rd SWEEP cycle -> mem_read=0 and all outputs 0 immediately. After release, a new active/halt run produces a full, correct sweep.
